// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the frame SRAM arbiter
// Purpose: state encoding, default geometry and read-tag bit positions.
// Ports: none (package).
package sram_arb_pkg;

   localparam int DEF_ADDR_W = 15;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32768;

   // Bit positions inside the one-hot read-return tag.
   localparam int TAG_HOST  = 0;
   localparam int TAG_VIDEO = 1;

   typedef enum logic [1:0] {
      RST_IDLE = 2'd0,
      CLEAR    = 2'd1,
      RUN      = 2'd2
   } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - video/host/SRAM bus bundle around the arbiter
// Purpose: groups both master request ports and the SRAM slave port.
// Ports: modport slave  = arbiter view (takes requests, drives SRAM);
//        modport master = environment view (issues requests, models SRAM).
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
);
   // video read port
   logic                  v_req;
   logic [ADDR_W-1:0]     v_addr;
   logic                  v_gnt;
   logic                  v_rvalid;
   logic [DATA_W-1:0]     v_rdata;
   // host read/write port
   logic                  h_req;
   logic                  h_write;
   logic [ADDR_W-1:0]     h_addr;
   logic [DATA_W/8-1:0]   h_byteenable;
   logic [DATA_W-1:0]     h_wdata;
   logic                  h_gnt;
   logic                  h_rvalid;
   logic [DATA_W-1:0]     h_rdata;
   // SRAM slave port
   logic [ADDR_W-1:0]     sram_address;
   logic [DATA_W/8-1:0]   sram_byteenable;
   logic                  sram_chipselect;
   logic                  sram_write;
   logic [DATA_W-1:0]     sram_writedata;
   logic [DATA_W-1:0]     sram_readdata;

   modport slave (
      input  v_req, v_addr,
      input  h_req, h_write, h_addr, h_byteenable, h_wdata,
      input  sram_readdata,
      output v_gnt, v_rvalid, v_rdata,
      output h_gnt, h_rvalid, h_rdata,
      output sram_address, sram_byteenable, sram_chipselect, sram_write, sram_writedata
   );

   modport master (
      output v_req, v_addr,
      output h_req, h_write, h_addr, h_byteenable, h_wdata,
      output sram_readdata,
      input  v_gnt, v_rvalid, v_rdata,
      input  h_gnt, h_rvalid, h_rdata,
      input  sram_address, sram_byteenable, sram_chipselect, sram_write, sram_writedata
   );

endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-port frame SRAM arbiter with zero-fill after reset
// Purpose: zero-fills DEPTH words after reset, then grants one access per cycle,
//          video first, with the host guaranteed a slot after MAX_STARVE losses.
// Ports: clk, reset_n (async, active low); init_done (high in RUN);
//        bus (slave modport): video read port, host read/write port, SRAM port.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int MAX_STARVE     = 4,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                init_done,
   sram_port_arbiter_if.slave  bus
);

   arb_state_e          state_q;
   logic [ADDR_W-1:0]   clr_cnt_q;
   logic [3:0]          starve_q, starve_d;
   logic [1:0]          rd_tag_q;
   logic                init_done_q;

   logic                run;
   logic                host_turn;
   logic                v_gnt;
   logic                h_gnt;

   always_comb begin
      run       = (state_q == RUN);
      // Host overrides video only once it has been passed over MAX_STARVE times in a row.
      host_turn = bus.v_req && bus.h_req && (starve_q == 4'(MAX_STARVE));
      v_gnt     = run && bus.v_req && !host_turn;
      h_gnt     = run && bus.h_req && !v_gnt;

      starve_d = '0;
      if (bus.h_req && v_gnt) begin
         starve_d = (starve_q == 4'(MAX_STARVE)) ? starve_q : starve_q + 4'd1;
      end
   end

   always_comb begin
      bus.sram_chipselect = 1'b0;
      bus.sram_write      = 1'b0;
      bus.sram_address    = '0;
      bus.sram_byteenable = '0;
      bus.sram_writedata  = '0;
      if (state_q == CLEAR) begin
         bus.sram_chipselect = 1'b1;
         bus.sram_write      = 1'b1;
         bus.sram_address    = clr_cnt_q;
         bus.sram_byteenable = '1;
      end else if (v_gnt) begin
         bus.sram_chipselect = 1'b1;
         bus.sram_address    = bus.v_addr;
         bus.sram_byteenable = '1;
      end else if (h_gnt) begin
         bus.sram_chipselect = 1'b1;
         bus.sram_write      = bus.h_write;
         bus.sram_address    = bus.h_addr;
         bus.sram_byteenable = bus.h_byteenable;
         bus.sram_writedata  = bus.h_wdata;
      end
   end

   assign bus.v_gnt    = v_gnt;
   assign bus.h_gnt    = h_gnt;
   assign bus.v_rvalid = rd_tag_q[TAG_VIDEO];
   assign bus.h_rvalid = rd_tag_q[TAG_HOST];
   assign bus.v_rdata  = bus.sram_readdata;
   assign bus.h_rdata  = bus.sram_readdata;
   assign init_done    = init_done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RST_IDLE;
         clr_cnt_q   <= '0;
         starve_q    <= '0;
         rd_tag_q    <= '0;
         init_done_q <= 1'b0;
      end else begin
         starve_q            <= starve_d;
         // Host writes return nothing, so only host reads set the host tag.
         rd_tag_q[TAG_VIDEO] <= v_gnt;
         rd_tag_q[TAG_HOST]  <= h_gnt && !bus.h_write;
         case (state_q)
            RST_IDLE: begin
               if (CLEAR_ON_RESET != 0) begin
                  state_q <= CLEAR;
               end else begin
                  state_q     <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                  state_q     <= RUN;
                  init_done_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
               end
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= RST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

   localparam int AW    = 15;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int MAXS  = 2;

   logic clk;
   logic reset_n;
   logic reset_n2;
   logic init_done;
   logic init_done2;

   int n_checks = 0;
   int n_errors = 0;

   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

   sram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_STARVE(MAXS), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .init_done(init_done), .bus(bus1.slave)
   );

   sram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_STARVE(MAXS), .CLEAR_ON_RESET(0)
   ) dut2 (
      .clk(clk), .reset_n(reset_n2), .init_done(init_done2), .bus(bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM behind dut: byte-enabled write, one-cycle read latency.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rdq;
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5_5A5A;
      rdq = '0;
   end
   always @(posedge clk) begin
      if (bus1.sram_chipselect) begin
         if (bus1.sram_write) begin
            for (int b = 0; b < DW/8; b++)
               if (bus1.sram_byteenable[b]) mem[bus1.sram_address][8*b +: 8] <= bus1.sram_writedata[8*b +: 8];
         end else begin
            rdq <= mem[bus1.sram_address];
         end
      end
   end
   assign bus1.sram_readdata = rdq;
   assign bus2.sram_readdata = 32'h0;

   // Reference model: expected memory image and host pass-over count.
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   int host_passed = 0;
   int obs_wait    = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic run_cycle(output bit gv, output bit gh);
      bit            ev, eh, vr, hr;
      logic [DW-1:0] vd, hd, merged;
      #1;
      ev = bus1.v_req && !(bus1.h_req && host_passed >= MAXS);
      eh = bus1.h_req && !ev;
      chk("v_gnt", bus1.v_gnt, ev);
      chk("h_gnt", bus1.h_gnt, eh);
      chk("sram_cs", bus1.sram_chipselect, ev || eh);
      vr = 0; hr = 0; vd = '0; hd = '0;
      if (ev) begin
         chk("v_sram_addr", bus1.sram_address, bus1.v_addr);
         chk("v_sram_write", bus1.sram_write, 1'b0);
         chk("v_sram_be", bus1.sram_byteenable, 4'hF);
         vr = 1;
         vd = ref_mem[bus1.v_addr[3:0]];
      end
      if (eh) begin
         chk("h_sram_addr", bus1.sram_address, bus1.h_addr);
         chk("h_sram_write", bus1.sram_write, bus1.h_write);
         chk("h_sram_be", bus1.sram_byteenable, bus1.h_byteenable);
         if (bus1.h_write) begin
            chk("h_sram_wdata", bus1.sram_writedata, bus1.h_wdata);
            merged = ref_mem[bus1.h_addr[3:0]];
            for (int b = 0; b < DW/8; b++)
               if (bus1.h_byteenable[b]) merged[8*b +: 8] = bus1.h_wdata[8*b +: 8];
            ref_mem[bus1.h_addr[3:0]] = merged;
         end else begin
            hr = 1;
            hd = ref_mem[bus1.h_addr[3:0]];
         end
      end
      if (!ev && !eh) chk("idle_write", bus1.sram_write, 1'b0);
      // Observed host wait must never exceed the starvation bound.
      if (bus1.h_req && bus1.h_gnt) begin
         chk("h_wait_bound", obs_wait <= MAXS, 1'b1);
         obs_wait = 0;
      end else if (bus1.h_req) begin
         obs_wait++;
      end else begin
         obs_wait = 0;
      end
      if (bus1.h_req && ev) host_passed++;
      else host_passed = 0;
      gv = ev; gh = eh;
      @(posedge clk);
      @(negedge clk);
      chk("v_rvalid", bus1.v_rvalid, vr);
      chk("h_rvalid", bus1.h_rvalid, hr);
      if (vr) chk("v_rdata", bus1.v_rdata, vd);
      if (hr) chk("h_rdata", bus1.h_rdata, hd);
   endtask

   task automatic check_reset_outputs(input string tag);
      #1;
      chk({tag, "_init_done"}, init_done, 1'b0);
      chk({tag, "_v_gnt"}, bus1.v_gnt, 1'b0);
      chk({tag, "_h_gnt"}, bus1.h_gnt, 1'b0);
      chk({tag, "_v_rvalid"}, bus1.v_rvalid, 1'b0);
      chk({tag, "_h_rvalid"}, bus1.h_rvalid, 1'b0);
      chk({tag, "_cs"}, bus1.sram_chipselect, 1'b0);
      chk({tag, "_we"}, bus1.sram_write, 1'b0);
      chk({tag, "_addr"}, bus1.sram_address, '0);
      chk({tag, "_be"}, bus1.sram_byteenable, '0);
      chk({tag, "_wdata"}, bus1.sram_writedata, '0);
   endtask

   // Starts at the negedge where reset_n was released, with both requests held high.
   task automatic clear_check();
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         chk("clr_cs", bus1.sram_chipselect, 1'b1);
         chk("clr_we", bus1.sram_write, 1'b1);
         chk("clr_addr", bus1.sram_address, AW'(i));
         chk("clr_wdata", bus1.sram_writedata, '0);
         chk("clr_be", bus1.sram_byteenable, 4'hF);
         chk("clr_v_gnt", bus1.v_gnt, 1'b0);
         chk("clr_h_gnt", bus1.h_gnt, 1'b0);
         chk("clr_init_done", init_done, 1'b0);
      end
      bus1.v_req = 0;
      bus1.h_req = 0;
      @(posedge clk);
      @(negedge clk);
      chk("init_done_rise", init_done, 1'b1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      host_passed = 0;
      obs_wait    = 0;
   endtask

   task automatic host_op(input bit wr, input int addr, input logic [3:0] be, input logic [DW-1:0] d);
      bus1.h_req = 1; bus1.h_write = wr; bus1.h_addr = AW'(addr);
      bus1.h_byteenable = be; bus1.h_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit gv, gh;
      bit vp, hp;
      bit seq_h [6] = '{0, 0, 1, 0, 0, 1};

      reset_n = 0; reset_n2 = 0;
      bus1.v_req = 1; bus1.v_addr = '0;
      bus1.h_req = 1; bus1.h_write = 0; bus1.h_addr = '0; bus1.h_byteenable = '0; bus1.h_wdata = '0;
      bus2.v_req = 0; bus2.v_addr = '0;
      bus2.h_req = 1; bus2.h_write = 0; bus2.h_addr = AW'(9); bus2.h_byteenable = 4'hF; bus2.h_wdata = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");

      // No-clear variant: RUN and host grant one cycle after release.
      @(negedge clk);
      reset_n2 = 1;
      #1;
      chk("nc_init_done_0", init_done2, 1'b0);
      chk("nc_h_gnt_0", bus2.h_gnt, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("nc_init_done_1", init_done2, 1'b1);
      chk("nc_h_gnt_1", bus2.h_gnt, 1'b1);
      chk("nc_cs_1", bus2.sram_chipselect, 1'b1);
      @(posedge clk);
      #1;
      bus2.h_req = 0;
      chk("nc_h_rvalid", bus2.h_rvalid, 1'b1);

      // Zero-fill after first release.
      @(negedge clk);
      reset_n = 1;
      clear_check();

      // Partial-byte host write then read back.
      host_op(1, 5, 4'b0011, 32'hDEADBEEF);
      run_cycle(gv, gh);
      host_op(0, 5, 4'hF, 32'h0);
      run_cycle(gv, gh);
      chk("beef_rvalid", bus1.h_rvalid, 1'b1);
      chk("beef_rdata", bus1.h_rdata, 32'h0000BEEF);
      chk("beef_v_rvalid", bus1.v_rvalid, 1'b0);
      bus1.h_req = 0;

      // Continuous contention: V,V,H repeating.
      bus1.v_req = 1; bus1.v_addr = AW'(7);
      host_op(0, 8, 4'hF, 32'h0);
      for (int i = 0; i < 6; i++) begin
         run_cycle(gv, gh);
         chk("contend_seq_h", gh, seq_h[i]);
         chk("contend_seq_v", gv, !seq_h[i]);
      end
      bus1.v_req = 0; bus1.h_req = 0;

      // Video read of a freshly written word.
      host_op(1, 3, 4'hF, 32'h12345678);
      run_cycle(gv, gh);
      bus1.h_req = 0;
      bus1.v_req = 1; bus1.v_addr = AW'(3);
      run_cycle(gv, gh);
      chk("v3_rvalid", bus1.v_rvalid, 1'b1);
      chk("v3_rdata", bus1.v_rdata, 32'h12345678);
      bus1.v_req = 0;
      run_cycle(gv, gh);
      chk("v3_rvalid_once", bus1.v_rvalid, 1'b0);

      // Randomized traffic.
      vp = 0; hp = 0;
      for (int c = 0; c < 400; c++) begin
         if (!vp && $urandom_range(3, 0) != 0) begin
            vp = 1;
            bus1.v_addr = AW'($urandom_range(DEPTH-1, 0));
         end
         if (!hp && $urandom_range(1, 0) != 0) begin
            hp = 1;
            host_op($urandom_range(1, 0), $urandom_range(DEPTH-1, 0), 4'($urandom), $urandom);
         end
         bus1.v_req = vp;
         bus1.h_req = hp;
         run_cycle(gv, gh);
         if (gv) vp = 0;
         if (gh) hp = 0;
      end
      bus1.v_req = 0; bus1.h_req = 0;
      @(negedge clk);

      // Reset the cycle after a video read grant: response dropped, clear re-runs.
      bus1.v_req = 1; bus1.v_addr = AW'(3);
      #1;
      chk("mid_v_gnt", bus1.v_gnt, 1'b1);
      @(posedge clk);
      #1;
      reset_n = 0;
      #1;
      chk("mid_rvalid_dropped", bus1.v_rvalid, 1'b0);
      bus1.v_req = 1; bus1.h_req = 1;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      @(negedge clk);
      reset_n = 1;
      clear_check();

      // Word written earlier must read back as zero after the second clear.
      host_op(0, 5, 4'hF, 32'h0);
      run_cycle(gv, gh);
      chk("reclear_rdata", bus1.h_rdata, 32'h0);
      bus1.h_req = 0;
      run_cycle(gv, gh);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-port on-chip frame SRAM (32768 x 32, byte-enabled, one-cycle read latency) between the VGA scan-out reader and the host/ultrasonic-data writer. After reset, a clear engine zero-fills the memory. The arbiter then grants one access per cycle using video-first priority with a bounded starvation guard for the host. It sits between both masters and the SRAM slave port.

## Interface
- ADDR_W, 15, SRAM word-address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- DEPTH, 32768, words cleared by the clear engine; must satisfy DEPTH <= 2^ADDR_W
- MAX_STARVE, 4, consecutive video wins tolerated while the host waits; range 1..15
- CLEAR_ON_RESET, 1, 1 = zero-fill after reset; 0 = go straight to run
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the arbiter is in RUN
- v_req  in  1  video read request; held until granted
- v_addr  in  ADDR_W  video read address
- v_gnt  out  1  video request accepted this cycle
- v_rvalid  out  1  v_rdata valid
- v_rdata  out  DATA_W  video read data
- h_req  in  1  host request; held until granted
- h_write  in  1  1 = write, 0 = read
- h_addr  in  ADDR_W  host address
- h_byteenable  in  DATA_W/8  host byte enables, applied on writes
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host request accepted this cycle
- h_rvalid  out  1  h_rdata valid
- h_rdata  out  DATA_W  host read data
- sram_address / sram_byteenable / sram_chipselect / sram_write / sram_writedata  out  ADDR_W / DATA_W/8 / 1 / 1 / DATA_W  SRAM slave port
- sram_readdata  in  DATA_W  SRAM read data, valid the cycle after the address is presented

## Operation
- States:
  - RST_IDLE: reset state; all outputs 0.
  - CLEAR: zero-fill in progress.
  - RUN: arbitration.
- Transitions:
  - RST_IDLE -> CLEAR on the first clock, if CLEAR_ON_RESET = 1.
  - RST_IDLE -> RUN on the first clock, if CLEAR_ON_RESET = 0.
  - CLEAR -> RUN after the write at clr_cnt == DEPTH-1.
- CLEAR behaviour:
  - Each cycle drives chipselect=1, write=1, byteenable all ones, writedata 0, address = clr_cnt.
  - clr_cnt starts at 0 and increments by 1 per cycle.
  - v_gnt and h_gnt stay 0; requests remain pending.
- RUN arbitration (grants are combinational):
  - Only v_req high: the video request is granted.
  - Only h_req high: the host request is granted.
  - Both high: video wins unless starve_cnt == MAX_STARVE, in which case the host wins.
- starve_cnt:
  - Increments when h_req is high and video wins.
  - Clears to 0 when the host is granted or h_req is low.
  - Saturates at MAX_STARVE.
- SRAM drive when a request is granted:
  - chipselect = 1.
  - address and writedata come from the winner.
  - write = h_write for a host grant, 0 for a video grant.
  - byteenable = h_byteenable for a host grant; all ones for a video grant.
- SRAM drive with no grant: chipselect=0, write=0; other SRAM outputs are don't-care.
- Read return:
  - rd_tag is a 2-bit register, one-hot {video, host}, recording which master's read was granted last cycle.
  - v_rvalid = rd_tag[video]; h_rvalid = rd_tag[host].
  - v_rdata and h_rdata are both sram_readdata, passed combinationally.
  - Host writes produce no response.
- Ordering: accesses complete in grant order; a read after a write to the same address returns the new data.
- Reset mid-operation:
  - State returns to RST_IDLE.
  - clr_cnt, starve_cnt and rd_tag clear; an in-flight read response is dropped.
  - The clear runs again (when CLEAR_ON_RESET = 1).

## Timing
- Reset values: every output is 0, including init_done, both grants, both rvalids and all sram_* outputs.
- Grant and request are in the same cycle; throughput is one access per cycle.
- Read latency: rvalid is asserted exactly 1 cycle after the grant, for exactly 1 cycle.
- init_done is registered and rises in the first RUN cycle.
  - CLEAR_ON_RESET = 1: rises DEPTH+1 cycles after reset release.
  - CLEAR_ON_RESET = 0: rises 1 cycle after reset release.
- Guaranteed host wait under continuous video load: at most MAX_STARVE cycles.

## Structure
- Package sram_arb_pkg holds:
  - the state enum {RST_IDLE, CLEAR, RUN};
  - default ADDR_W, DATA_W and DEPTH constants;
  - the rd_tag bit indices.
- No sub-module: clear counter, starvation counter and grant mux together form one compact module.

## Test plan
Run with DEPTH=16 and MAX_STARVE=2 unless stated.
- Reset release -> 16 consecutive writes to addresses 0..15 (data 0, byteenable 4'hF); init_done rises 17 cycles after release; no grants during the clear.
- Host write, addr 5, data 0xDEADBEEF, byteenable 4'b0011, then host read addr 5 -> h_rvalid one cycle after the read grant with h_rdata = 0x0000BEEF; v_rvalid stays 0.
- v_req and h_req both held high continuously -> grant sequence V,V,H,V,V,H; starve_cnt never exceeds 2.
- Video read of addr 3 granted at cycle t -> v_rvalid high only at t+1 with the SRAM content; sram_write = 0 at t.
- reset_n pulled low the cycle after a video read grant -> v_rvalid is 0; after release the clear re-runs (16 writes) before any grant.
- CLEAR_ON_RESET=0 -> init_done at cycle 1 after release; a host request pending at that cycle is granted the same cycle.
